sort5_sequencer: RTL and testbench

Initiator-side controller for the team's 5-input, mod-phased merge sorter. Accepts a serial stream of W-bit words over a valid/ready slave port and groups them into frames of 5. For each frame it drives the sorter through phases mod=00, 01 and 10, captures the sorter's five outputs, and streams them out in ascending order on a valid/ready master port.

---
 rtl/sort5_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sort5_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sort5_sequencer.sv
// Frames a serial word stream into groups of five, steps the mod-phased sorter through phases 00/01/10,
// then drains the captured results in ascending order. Define SORT_CHECK_EN to add the sticky order checker.
module sort5_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic [W-1:0] srt_in1,
    output logic [W-1:0] srt_in2,
    output logic [W-1:0] srt_in3,
    output logic [W-1:0] srt_in4,
    output logic [W-1:0] srt_in5,
    output logic [1:0]   srt_mod,
    input  logic [W-1:0] srt_out1,
    input  logic [W-1:0] srt_out2,
    input  logic [W-1:0] srt_out3,
    input  logic [W-1:0] srt_out4,
    input  logic [W-1:0] srt_out5,
    output logic         busy,
    output logic         sort_err
);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_PH0   = 3'd1,
        ST_PH1   = 3'd2,
        ST_PH2   = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    state_t       state_r, state_nx_s;
    logic [2:0]   cnt_r, cnt_nx_s;
    logic [2:0]   idx_r, idx_nx_s, idx_inc_s;
    logic [W-1:0] in_r   [5];
    logic [W-1:0] obuf_r [5];
    logic [W-1:0] out_s  [5];
    logic         s_ready_r, m_valid_r, m_last_r, busy_r;
    logic         m_valid_nx_s, m_last_nx_s;
    logic [W-1:0] m_data_r, m_data_nx_s;
    logic [1:0]   srt_mod_r, srt_mod_nx_s;
    logic         acc_s, take_s;

    assign acc_s     = s_valid & s_ready_r;
    assign take_s    = m_valid_r & m_ready;
    assign idx_inc_s = idx_r + 3'd1;

    assign out_s[0] = srt_out1;
    assign out_s[1] = srt_out2;
    assign out_s[2] = srt_out3;
    assign out_s[3] = srt_out4;
    assign out_s[4] = srt_out5;

    // Next-state and next-output computation; every output is registered from these values.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        idx_nx_s     = idx_r;
        m_valid_nx_s = m_valid_r;
        m_last_nx_s  = m_last_r;
        m_data_nx_s  = m_data_r;
        case (state_r)
            ST_LOAD: begin
                if (acc_s) begin
                    if (cnt_r == 3'd4) begin
                        cnt_nx_s   = 3'd0;
                        state_nx_s = ST_PH0;
                    end else begin
                        cnt_nx_s = cnt_r + 3'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            ST_PH0:  state_nx_s = ST_PH1;
            ST_PH1:  state_nx_s = ST_PH2;
            ST_PH2:  state_nx_s = ST_CAPT;
            ST_CAPT: begin
                state_nx_s   = ST_DRAIN;
                idx_nx_s     = 3'd0;
                m_valid_nx_s = 1'b1;
                m_last_nx_s  = 1'b0;
                m_data_nx_s  = out_s[0];
            end
            ST_DRAIN: begin
                if (take_s) begin
                    if (idx_r == 3'd4) begin
                        idx_nx_s     = 3'd0;
                        m_valid_nx_s = 1'b0;
                        m_last_nx_s  = 1'b0;
                        state_nx_s   = ST_LOAD;
                    end else begin
                        idx_nx_s    = idx_inc_s;
                        m_data_nx_s = obuf_r[idx_inc_s];
                        m_last_nx_s = (idx_inc_s == 3'd4);
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            default: begin
                state_nx_s   = ST_LOAD;
                cnt_nx_s     = 3'd0;
                idx_nx_s     = 3'd0;
                m_valid_nx_s = 1'b0;
                m_last_nx_s  = 1'b0;
            end
        endcase
    end

    // Sorter phase select follows the state being entered, so it is valid for that whole cycle.
    always_comb begin
        case (state_nx_s)
            ST_PH0:  srt_mod_nx_s = 2'b00;
            ST_PH1:  srt_mod_nx_s = 2'b01;
            ST_PH2:  srt_mod_nx_s = 2'b10;
            default: srt_mod_nx_s = 2'b11;
        endcase
    end

    // State, counters, operand/result buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            cnt_r     <= 3'd0;
            idx_r     <= 3'd0;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= {W{1'b0}};
            srt_mod_r <= 2'b11;
            busy_r    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                in_r[i]   <= {W{1'b0}};
                obuf_r[i] <= {W{1'b0}};
            end
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            idx_r     <= idx_nx_s;
            s_ready_r <= (state_nx_s == ST_LOAD);
            m_valid_r <= m_valid_nx_s;
            m_last_r  <= m_last_nx_s;
            m_data_r  <= m_data_nx_s;
            srt_mod_r <= srt_mod_nx_s;
            busy_r    <= (state_nx_s != ST_LOAD);
            if ((state_r == ST_LOAD) && acc_s) begin
                in_r[cnt_r] <= s_data;
            end
            if (state_r == ST_CAPT) begin
                for (int i = 0; i < 5; i++) begin
                    obuf_r[i] <= out_s[i];
                end
            end
        end
    end

`ifdef SORT_CHECK_EN
    function automatic logic order_bad(input logic [W-1:0] a1, input logic [W-1:0] a2,
                                       input logic [W-1:0] a3, input logic [W-1:0] a4,
                                       input logic [W-1:0] a5);
        return (a1 > a2) | (a2 > a3) | (a3 > a4) | (a4 > a5);
    endfunction

    logic sort_err_r;

    // Sticky flag, sampled on the edge that leaves CAPT; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sort_err_r <= 1'b0;
        end else if (state_r == ST_CAPT) begin
            sort_err_r <= sort_err_r | order_bad(srt_out1, srt_out2, srt_out3, srt_out4, srt_out5);
        end
    end

    assign sort_err = sort_err_r;
`else
    assign sort_err = 1'b0;
`endif

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign srt_mod = srt_mod_r;
    assign busy    = busy_r;
    assign srt_in1 = in_r[0];
    assign srt_in2 = in_r[1];
    assign srt_in3 = in_r[2];
    assign srt_in4 = in_r[3];
    assign srt_in5 = in_r[4];

endmodule

// File: tb/tb_sort5_sequencer.sv
// Bench for sort5_sequencer: behavioural sorter plus a sorted-frame reference, directed and random frames.
`timescale 1ns/1ps
module tb_sort5_sequencer;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, m_valid, m_ready, m_last, busy, sort_err, bad_mode;
    logic [15:0] s_data, m_data;
    logic [15:0] srt_in1, srt_in2, srt_in3, srt_in4, srt_in5;
    logic [1:0]  srt_mod;
    logic [79:0] so_v = 80'd0;
    logic [15:0] fw  [5];
    logic [15:0] sin [5];
    int          n_checks = 0;
    int          n_pass = 0;

`ifdef SORT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sort5_sequencer #(.W(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .srt_in1(srt_in1), .srt_in2(srt_in2), .srt_in3(srt_in3), .srt_in4(srt_in4), .srt_in5(srt_in5),
        .srt_mod(srt_mod),
        .srt_out1(so_v[15:0]), .srt_out2(so_v[31:16]), .srt_out3(so_v[47:32]),
        .srt_out4(so_v[63:48]), .srt_out5(so_v[79:64]),
        .busy(busy), .sort_err(sort_err)
    );

    assign sin[0] = srt_in1;
    assign sin[1] = srt_in2;
    assign sin[2] = srt_in3;
    assign sin[3] = srt_in4;
    assign sin[4] = srt_in5;

    function automatic logic [79:0] sort5(input logic [79:0] v);
        logic [15:0] a [5];
        logic [15:0] t;
        logic [79:0] r;
        for (int i = 0; i < 5; i++) a[i] = v[i*16 +: 16];
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 5; i++) r[i*16 +: 16] = a[i];
        return r;
    endfunction

    function automatic logic [79:0] corrupt(input logic [79:0] v, input logic bad);
        logic [79:0] r;
        r = v;
        if (bad) begin
            r[31:16] = 16'd10;
            r[47:32] = 16'd5;
        end
        return r;
    endfunction

    // Sorter model: results appear on the edge that ends phase 10
    always @(posedge clk) begin
        if (srt_mod == 2'b10)
            so_v <= corrupt(sort5({srt_in5, srt_in4, srt_in3, srt_in2, srt_in1}), bad_mode);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && guard < 50) begin tick(); guard++; end
        if (guard >= 50) check_value("s_ready_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic run_frame(input int gap_mode, input int stall_at, input int stall_len, input logic bad);
        logic [79:0] ev;
        int g;
        bad_mode = bad;
        ev = corrupt(sort5({fw[4], fw[3], fw[2], fw[1], fw[0]}), bad);
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = (gap_mode == 1) ? (k % 2) : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            if (g > 0) begin
                s_valid = 1'b0;
                repeat (g) tick();
            end
            load_word(fw[k]);
        end
        check_value("s_ready_after_5th", 32'(s_ready), 32'd0);
        check_value("busy_ph0", 32'(busy), 32'd1);
        check_value("mod_ph0", 32'(srt_mod), 32'd0);
        tick();
        check_value("mod_ph1", 32'(srt_mod), 32'd1);
        tick();
        check_value("mod_ph2", 32'(srt_mod), 32'd2);
        tick();
        check_value("mod_capt", 32'(srt_mod), 32'd3);
        check_value("m_valid_early", 32'(m_valid), 32'd0);
        tick();
        check_value("m_valid_latency", 32'(m_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == stall_at) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check_value("stall_data", 32'(m_data), 32'(ev[i*16 +: 16]));
                    check_value("stall_valid", 32'(m_valid), 32'd1);
                end
                m_ready = 1'b1;
            end
            check_value("m_valid", 32'(m_valid), 32'd1);
            check_value("m_data", 32'(m_data), 32'(ev[i*16 +: 16]));
            check_value("m_last", 32'(m_last), 32'(i == 4));
            check_value("s_ready_drain", 32'(s_ready), 32'd0);
            tick();
        end
        check_value("m_valid_end", 32'(m_valid), 32'd0);
        check_value("s_ready_end", 32'(s_ready), 32'd1);
        check_value("busy_end", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) check_value("srt_in_hold", 32'(sin[k]), 32'(fw[k]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = 1'b0; s_data = 16'd0; m_ready = 1'b0; bad_mode = 1'b0;
        do_reset(3);
        rst = 1'b1;
        tick();
        check_value("rst_s_ready", 32'(s_ready), 32'd0);
        check_value("rst_m_valid", 32'(m_valid), 32'd0);
        check_value("rst_m_data", 32'(m_data), 32'd0);
        check_value("rst_m_last", 32'(m_last), 32'd0);
        check_value("rst_mod", 32'(srt_mod), 32'd3);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_sort_err", 32'(sort_err), 32'd0);
        check_value("rst_srt_in1", 32'(srt_in1), 32'd0);
        rst = 1'b0;
        tick();
        check_value("s_ready_rise", 32'(s_ready), 32'd1);

        // basic sort, back-to-back
        fw[0] = 16'd5; fw[1] = 16'd3; fw[2] = 16'd9; fw[3] = 16'd1; fw[4] = 16'd7;
        run_frame(0, 9, 0, 1'b0);
        check_value("sort_err_clean", 32'(sort_err), 32'd0);

        // gaps and backpressure at idx 2
        fw[0] = 16'd100; fw[1] = 16'd2; fw[2] = 16'd50; fw[3] = 16'd2; fw[4] = 16'hFFFF;
        run_frame(1, 2, 3, 1'b0);

        // back-to-back frames
        fw[0] = 16'd8; fw[1] = 16'd6; fw[2] = 16'd4; fw[3] = 16'd2; fw[4] = 16'd0;
        run_frame(0, 9, 0, 1'b0);
        for (int k = 0; k < 5; k++) fw[k] = 16'd1;
        run_frame(0, 9, 0, 1'b0);

        // reset mid-drain at idx 2
        fw[0] = 16'd40; fw[1] = 16'd30; fw[2] = 16'd20; fw[3] = 16'd10; fw[4] = 16'd0;
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) load_word(fw[k]);
        repeat (4) tick();
        check_value("md_valid", 32'(m_valid), 32'd1);
        repeat (2) tick();
        check_value("md_idx2_data", 32'(m_data), 32'd20);
        do_reset(1);
        check_value("md_rst_valid", 32'(m_valid), 32'd0);
        check_value("md_rst_mod", 32'(srt_mod), 32'd3);
        check_value("md_rst_s_ready", 32'(s_ready), 32'd0);
        tick();
        check_value("md_s_ready", 32'(s_ready), 32'd1);
        fw[0] = 16'd4; fw[1] = 16'd3; fw[2] = 16'd2; fw[3] = 16'd1; fw[4] = 16'd0;
        run_frame(0, 9, 0, 1'b0);

        // reset mid-load after 3 words
        load_word(16'd77); load_word(16'd88); load_word(16'd99);
        do_reset(1);
        fw[0] = 16'd9; fw[1] = 16'd8; fw[2] = 16'd7; fw[3] = 16'd6; fw[4] = 16'd5;
        run_frame(0, 9, 0, 1'b0);

        // random frames, small range to force duplicates on odd frames
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 5; k++)
                fw[k] = (f % 2 == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            run_frame(2, int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), 1'b0);
        end

        // faulty sorter output: flagged only when the checker is built in, data still drained
        fw[0] = 16'd1; fw[1] = 16'd2; fw[2] = 16'd3; fw[3] = 16'd4; fw[4] = 16'd20;
        run_frame(0, 9, 0, 1'b1);
        check_value("sort_err_set", 32'(sort_err), 32'(ERR_EXP));
        fw[0] = 16'd12; fw[1] = 16'd11; fw[2] = 16'd14; fw[3] = 16'd13; fw[4] = 16'd15;
        run_frame(0, 9, 0, 1'b0);
        check_value("sort_err_sticky", 32'(sort_err), 32'(ERR_EXP));
        do_reset(1);
        check_value("sort_err_rst", 32'(sort_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
